// File: rtl/sub_arbiter_pkg.sv
// Shared definitions for the two-requester subtract arbiter: datapath width,
// result-slot state encoding and requester id type.
package sub_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage : sub_arbiter_pkg

// File: rtl/sub_arbiter_sub.sv
// Shared subtract unit: purely combinational a - b, wrapping modulo 2^DATA_W.
module sub_arbiter_sub
  import sub_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff
);

  assign diff = a - b;

endmodule : sub_arbiter_sub

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtractor between two requesters, with a
// one-entry result slot. Define SUB_ARBITER_FLAGS_EN to add rsp_zero/rsp_borrow.
module sub_arbiter
  import sub_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_diff
`ifdef SUB_ARBITER_FLAGS_EN
  ,
  output logic              rsp_zero,
  output logic              rsp_borrow
`endif
);

  slot_state_e state_q, state_d;
  req_id_t     last_grant_q, last_grant_d;
  req_id_t     id_q, id_d;
  data_t       diff_q, diff_d;

  logic    can_accept;
  logic    grant0, grant1, grant_any;
  req_id_t grant_id;
  data_t   op_a, op_b, sub_diff;

  // A draining slot can be refilled in the same cycle, giving full throughput.
  // Grants are masked while reset is asserted so both readys read 0.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    grant0     = rst_n && can_accept && req0_valid && (!req1_valid || (last_grant_q == REQ1));
    grant1     = rst_n && can_accept && req1_valid && (!req0_valid || (last_grant_q == REQ0));
    grant_any  = grant0 || grant1;
    grant_id   = grant1 ? REQ1 : REQ0;
    op_a       = (grant_id == REQ1) ? req1_a : req0_a;
    op_b       = (grant_id == REQ1) ? req1_b : req0_b;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  sub_arbiter_sub u_sub (
    .a    (op_a),
    .b    (op_b),
    .diff (sub_diff)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    diff_d       = diff_q;
    if (grant_any) begin
      state_d      = ST_FULL;
      last_grant_d = grant_id;
      id_d         = grant_id;
      diff_d       = sub_diff;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= REQ1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= REQ0;
      diff_q <= '0;
    end else begin
      id_q   <= id_d;
      diff_q <= diff_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_diff  = diff_q;

`ifdef SUB_ARBITER_FLAGS_EN
  logic zero_q, borrow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else if (grant_any) begin
      zero_q   <= (sub_diff == '0);
      borrow_q <= (op_a < op_b);
    end
  end

  assign rsp_zero   = zero_q;
  assign rsp_borrow = borrow_q;
`endif

endmodule : sub_arbiter

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_sub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_diff;
`ifdef SUB_ARBITER_FLAGS_EN
  logic        rsp_zero, rsp_borrow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sub_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff)
`ifdef SUB_ARBITER_FLAGS_EN
    ,
    .rsp_zero   (rsp_zero),
    .rsp_borrow (rsp_borrow)
`endif
  );

  typedef struct packed {
    logic [31:0] diff;
    logic        zero;
    logic        borrow;
  } rec_t;

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // {rsp_valid, rsp_id, rsp_diff, req0_ready, req1_ready}
  function automatic logic [35:0] obs();
    return {rsp_valid, rsp_id, rsp_diff, req0_ready, req1_ready};
  endfunction

  task automatic test_reset();
    logic [35:0] got;
    rst_n = 1'b0;
    drive(1, 32'd1, 32'd1, 1, 32'd2, 32'd2, 1);
    repeat (2) @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== 36'd0) $display("FAIL reset_outputs: got %h expected %h", got, 36'd0);
    else n_pass++;
`ifdef SUB_ARBITER_FLAGS_EN
    n_checks++;
    if ({rsp_zero, rsp_borrow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {rsp_zero, rsp_borrow});
    else n_pass++;
`endif
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_contention();
    logic [35:0] exp;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'(100 + i), 32'(i), 1, 32'(200 + i), 32'(2 * i), 1);
      @(negedge clk);
      if (i == 0) exp = {1'b0, 1'b0, 32'd0, 2'b10};
      else begin
        d   = ((i - 1) % 2 == 0) ? 32'd100 : 32'(200 - (i - 1));
        exp = {1'b1, 1'(((i - 1) % 2)), d, (i % 2 == 0) ? 2'b10 : 2'b01};
      end
      n_checks++;
      if (obs() !== exp) $display("FAIL contention_%0d: got %h expected %h", i, obs(), exp);
      else n_pass++;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b1, 32'd195, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL contention_drain: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_single();
    logic [35:0] exp;
    drive(1, 32'd10, 32'd3, 0, 0, 0, 1);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010)
      $display("FAIL single_grant: got %b expected 010", {rsp_valid, req0_ready, req1_ready});
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b0, 32'd7, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL single_result: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_empty: got %b expected 0", rsp_valid);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    drive(0, 0, 0, 1, 32'd50, 32'd8, 0);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001)
      $display("FAIL bp_grant: got %b expected 001", {rsp_valid, req0_ready, req1_ready});
    else n_pass++;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'd9, 32'd4, 0, 0, 0, 0);
      @(negedge clk);
      exp = {1'b1, 1'b1, 32'd42, 2'b00};
      n_checks++;
      if (obs() !== exp) $display("FAIL bp_stall_%0d: got %h expected %h", i, obs(), exp);
      else n_pass++;
      next_cycle();
    end
    drive(1, 32'd9, 32'd4, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b1, 32'd42, 2'b10};
    n_checks++;
    if (obs() !== exp) $display("FAIL bp_release: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b0, 32'd5, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL bp_next: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", rsp_valid);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [35:0] exp;
    drive(1, 32'd0, 32'd1, 0, 0, 0, 1);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010)
      $display("FAIL wrap_grant: got %b expected 010", {rsp_valid, req0_ready, req1_ready});
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 1, 32'd5, 32'd5, 1);
    @(negedge clk);
    exp = {1'b1, 1'b0, 32'hFFFF_FFFF, 2'b01};
    n_checks++;
    if (obs() !== exp) $display("FAIL wrap_result: got %h expected %h", obs(), exp);
    else n_pass++;
`ifdef SUB_ARBITER_FLAGS_EN
    n_checks++;
    if ({rsp_zero, rsp_borrow} !== 2'b01) $display("FAIL wrap_flags: got %b expected 01", {rsp_zero, rsp_borrow});
    else n_pass++;
`endif
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b1, 32'd0, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL zero_result: got %h expected %h", obs(), exp);
    else n_pass++;
`ifdef SUB_ARBITER_FLAGS_EN
    n_checks++;
    if ({rsp_zero, rsp_borrow} !== 2'b10) $display("FAIL zero_flags: got %b expected 10", {rsp_zero, rsp_borrow});
    else n_pass++;
`endif
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp;
    drive(1, 32'd7, 32'd2, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010)
      $display("FAIL rmid_grant: got %b expected 010", {rsp_valid, req0_ready, req1_ready});
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = {1'b1, 1'b0, 32'd5, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL rmid_held: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
    drive(1, 32'd1, 32'd1, 1, 32'd1, 32'd1, 1);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 36'd0) $display("FAIL rmid_async: got %h expected %h", obs(), 36'd0);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(1, 32'd20, 32'd5, 1, 32'd30, 32'd4, 1);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010)
      $display("FAIL rmid_first: got %b expected 010", {rsp_valid, req0_ready, req1_ready});
    else n_pass++;
    next_cycle();
    @(negedge clk);
    exp = {1'b1, 1'b0, 32'd15, 2'b01};
    n_checks++;
    if (obs() !== exp) $display("FAIL rmid_second: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = {1'b1, 1'b1, 32'd26, 2'b00};
    n_checks++;
    if (obs() !== exp) $display("FAIL rmid_third: got %h expected %h", obs(), exp);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] pa0[512], pb0[512], pa1[512], pb1[512];
    rec_t        q0[$], q1[$];
    rec_t        r;
    int          i0 = 0, i1 = 0, delivered = 0, cyc = 0;
    logic        m_full = 1'b0, m_id = 1'b0, m_last = 1'b1;
    logic        v0, v1, rr, take, g0, g1;

    for (int k = 0; k < 512; k++) begin
      pa0[k] = $urandom; pb0[k] = $urandom;
      pa1[k] = $urandom; pb1[k] = $urandom;
      if (k % 64 == 0) begin pb0[k] = pa0[k]; pa1[k] = 32'd0; pb1[k] = 32'd1; end
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    while (delivered < 1024 && cyc < 20000) begin
      v0 = (i0 < 512) && ($urandom_range(0, 3) != 0);
      v1 = (i1 < 512) && ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      drive(v0, (i0 < 512) ? pa0[i0] : 32'd0, (i0 < 512) ? pb0[i0] : 32'd0,
            v1, (i1 < 512) ? pa1[i1] : 32'd0, (i1 < 512) ? pb1[i1] : 32'd0, rr);
      @(negedge clk);

      // Reference: the slot is free unless it holds a result nobody takes;
      // a free slot goes to the lone requester, or alternates under contention.
      take = m_full && rr;
      g0 = 1'b0; g1 = 1'b0;
      if (!m_full || rr) begin
        if (v0 && v1) begin
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
        end else begin
          g0 = v0; g1 = v1;
        end
      end

      n_checks++;
      if ({req0_ready, req1_ready} !== {g0, g1})
        $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, {req0_ready, req1_ready}, {g0, g1});
      else n_pass++;
      n_checks++;
      if (rsp_valid !== m_full) $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, rsp_valid, m_full);
      else n_pass++;

      if (take) begin
        n_checks++;
        if (rsp_id !== m_id) $display("FAIL rand_id cyc %0d: got %b expected %b", cyc, rsp_id, m_id);
        else n_pass++;
        if ((m_id ? q1.size() : q0.size()) == 0) begin
          n_checks++;
          $display("FAIL rand_extra cyc %0d: got result with no outstanding request for id %0d", cyc, m_id);
        end else begin
          r = m_id ? q1.pop_front() : q0.pop_front();
          n_checks++;
          if (rsp_diff !== r.diff) $display("FAIL rand_diff cyc %0d: got %h expected %h", cyc, rsp_diff, r.diff);
          else n_pass++;
`ifdef SUB_ARBITER_FLAGS_EN
          n_checks++;
          if ({rsp_zero, rsp_borrow} !== {r.zero, r.borrow})
            $display("FAIL rand_flags cyc %0d: got %b expected %b", cyc, {rsp_zero, rsp_borrow}, {r.zero, r.borrow});
          else n_pass++;
`endif
        end
        delivered++;
      end

      if (g0) begin
        r.diff = pa0[i0] - pb0[i0]; r.zero = (pa0[i0] == pb0[i0]); r.borrow = (pa0[i0] < pb0[i0]);
        q0.push_back(r); i0++;
        m_full = 1'b1; m_id = 1'b0; m_last = 1'b0;
      end else if (g1) begin
        r.diff = pa1[i1] - pb1[i1]; r.zero = (pa1[i1] == pb1[i1]); r.borrow = (pa1[i1] < pb1[i1]);
        q1.push_back(r); i1++;
        m_full = 1'b1; m_id = 1'b1; m_last = 1'b1;
      end else if (take) begin
        m_full = 1'b0;
      end
      next_cycle();
      cyc++;
    end

    n_checks++;
    if (delivered != 1024 || i0 != 512 || i1 != 512)
      $display("FAIL rand_count: got delivered=%0d sent0=%0d sent1=%0d expected 1024/512/512 within budget",
               delivered, i0, i1);
    else n_pass++;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL rand_lost: got %0d/%0d undelivered expected 0/0", q0.size(), q1.size());
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sub_arbiter
